// File: rtl/dp_ram_param.sv
// Simple dual-port RAM with byte-enable writes, a zero-fill sweep after reset and selectable read-during-write.
// Read latency is 1 cycle, or 2 with OUT_REG; no back-pressure, and requests are dropped while init_busy is high.
module dp_ram_param #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 6,
  parameter int OUT_REG = 0,
  parameter int BYPASS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     w_addr,
  input  logic [DATA_W-1:0]     w_data,
  input  logic [DATA_W/8-1:0]   w_be,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     r_addr,
  output logic [DATA_W-1:0]     r_data,
  output logic                  r_valid,
  output logic                  init_busy
);
  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {INIT, READY} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                s1_vld_q, s1_vld_d;
  logic [DATA_W-1:0]   s1_dat_q, s1_dat_d;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [BE_W-1:0]     mem_be;
  logic [DATA_W-1:0]   rd_word;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    s1_vld_d  = 1'b0;
    s1_dat_d  = s1_dat_q;
    mem_we    = 1'b0;
    mem_addr  = w_addr;
    mem_wdata = w_data;
    mem_be    = w_be;

    // Same-address collision: forward the enabled write bytes over the stored word.
    rd_word = mem[r_addr];
    for (int i = 0; i < BE_W; i++) begin
      if (BYPASS != 0 && we && w_be[i] && (w_addr == r_addr)) begin
        rd_word[8*i +: 8] = w_data[8*i +: 8];
      end
    end

    case (state_q)
      INIT: begin
        mem_we    = 1'b1;
        mem_addr  = cnt_q;
        mem_wdata = '0;
        mem_be    = '1;
        cnt_d     = cnt_q + 1'b1;
        if (&cnt_q) begin
          state_d = READY;
          busy_d  = 1'b0;
        end
      end
      READY: begin
        mem_we = we;
        if (re) begin
          s1_vld_d = 1'b1;
          s1_dat_d = rd_word;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= INIT;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
      s1_vld_q <= 1'b0;
      s1_dat_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      s1_vld_q <= s1_vld_d;
      s1_dat_q <= s1_dat_d;
    end
  end

  // Array itself has no reset; a held rst suppresses the sweep write.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (mem_be[i]) begin
          mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic              s2_vld_q, s2_vld_d;
      logic [DATA_W-1:0] s2_dat_q, s2_dat_d;

      always_comb begin
        s2_vld_d = s1_vld_q;
        s2_dat_d = s1_vld_q ? s1_dat_q : s2_dat_q;
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          s2_vld_q <= 1'b0;
          s2_dat_q <= '0;
        end else begin
          s2_vld_q <= s2_vld_d;
          s2_dat_q <= s2_dat_d;
        end
      end

      assign r_data  = s2_dat_q;
      assign r_valid = s2_vld_q;
    end else begin : g_no_out_reg
      assign r_data  = s1_dat_q;
      assign r_valid = s1_vld_q;
    end
  endgenerate

  assign init_busy = busy_q;

endmodule
